// File: rtl/mem_data_stage.sv
// Memory-data-register stage for the phase-sequenced CPU.
// At the configured capture phase it either loads the MDR from the internal
// data bus or issues a req/ready memory access (read into the MDR, or write
// of the MDR). While an access is outstanding the phase sequencer is stalled;
// an access that never completes is aborted after MAX_WAIT wait cycles and
// flagged through a sticky timeout error.
module mem_data_stage #(
  parameter int                  WIDTH         = 16,
  parameter int                  ADDR_WIDTH    = 16,
  parameter int                  PHASE_W       = 3,
  parameter logic [PHASE_W-1:0]  CAPTURE_PHASE = 3'b100,
  parameter int                  MAX_WAIT      = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PHASE_W-1:0]    phase_counter,
  input  logic                  op_mdr,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0]      data_bus,
  input  logic [WIDTH-1:0]      outside_input,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [WIDTH-1:0]      mdr_out,
  output logic                  stall,
  output logic                  timeout_err
);

  // Wait counter is 8 bits wide, enough for MAX_WAIT up to 255.
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_wait_cnt;

  logic w_at_phase;
  logic w_start_read;
  logic w_start_write;
  logic w_in_wait;
  logic w_timeout;

  // Decode of request starts and the timeout abort condition.
  always_comb begin
    w_at_phase    = (phase_counter == CAPTURE_PHASE);
    w_in_wait     = (r_state == S_WAIT);
    w_start_read  = !w_in_wait && w_at_phase && op_mdr && mem_read;
    // A simultaneous read request takes priority over the write.
    w_start_write = !w_in_wait && w_at_phase && op_mdr && mem_write && !mem_read;
    w_timeout     = w_in_wait && !mem_ready && (r_wait_cnt == MAX_WAIT_C);
  end

  // Freeze the sequencer from the request cycle until ready arrives; the
  // aborting timeout cycle releases it so the CPU can move on.
  always_comb begin
    stall = w_start_read || w_start_write ||
            (w_in_wait && !mem_ready && !w_timeout);
  end

  // MDR, memory request registers and the IDLE/WAIT sequencing.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 8'd0;
      mdr_out     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_at_phase) begin
            if (!op_mdr) begin
              mdr_out <= data_bus;
            end else if (w_start_read) begin
              mem_addr <= addr_in;
              mem_we   <= 1'b0;
              mem_req  <= 1'b1;
              r_state  <= S_WAIT;
            end else if (w_start_write) begin
              mem_addr  <= addr_in;
              mem_wdata <= mdr_out;
              mem_we    <= 1'b1;
              mem_req   <= 1'b1;
              r_state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            // mem_we still encodes the direction of the outstanding access.
            if (!mem_we) begin
              mdr_out <= outside_input;
            end
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            r_wait_cnt <= 8'd0;
            r_state    <= S_IDLE;
          end else if (w_timeout) begin
            timeout_err <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            r_wait_cnt  <= 8'd0;
            r_state     <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_stage.sv
// Testbench for mem_data_stage: bus captures, memory reads/writes with wait
// states, read/write priority, timeout abort, and reset during an access.
module tb_mem_data_stage;

  logic        clock;
  logic        reset;
  logic [2:0]  phase_counter;
  logic        op_mdr;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] addr_in;
  logic [15:0] data_bus;
  logic [15:0] outside_input;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mdr_out;
  logic        stall;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] model_mdr;
  logic [15:0] model_wdata;
  logic        model_to;

  mem_data_stage #(
    .WIDTH(16), .ADDR_WIDTH(16), .PHASE_W(3),
    .CAPTURE_PHASE(3'b100), .MAX_WAIT(15)
  ) dut (
    .clock(clock), .reset(reset), .phase_counter(phase_counter),
    .op_mdr(op_mdr), .mem_read(mem_read), .mem_write(mem_write),
    .addr_in(addr_in), .data_bus(data_bus), .outside_input(outside_input),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mdr_out(mdr_out),
    .stall(stall), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_mdr(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, mdr_out, e);
    end
  endtask

  task automatic idle_inputs();
    phase_counter = 3'd0;
    op_mdr        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_ready     = 1'b0;
  endtask

  task automatic bus_load(input logic [15:0] val);
    phase_counter = 3'd4;
    op_mdr        = 1'b0;
    data_bus      = val;
    model_mdr     = val;
    exp_q.push_back(val);
    #1 check("bus_stall", stall, 1'b0);
    tick();
    idle_inputs();
    pop_mdr("bus_mdr");
    check("bus_req", mem_req, 1'b0);
  endtask

  // waits = ready-low cycles before ready (or before the abort cycle).
  task automatic mem_op(input logic rd, input logic wr, input logic [15:0] addr,
                        input int waits, input logic [15:0] rdata, input logic to);
    phase_counter = 3'd4;
    op_mdr        = 1'b1;
    mem_read      = rd;
    mem_write     = wr;
    addr_in       = addr;
    if (!rd) model_wdata = model_mdr;
    if (rd && !to) model_mdr = rdata;
    exp_q.push_back(model_mdr);
    #1 check("start_stall", stall, 1'b1);
    tick();
    check("req_on", mem_req, 1'b1);
    check("req_addr", mem_addr, addr);
    check("req_we", mem_we, !rd);
    check("req_wdata", mem_wdata, model_wdata);
    // Inputs other than ready are ignored while waiting.
    addr_in   = ~addr;
    op_mdr    = 1'b0;
    data_bus  = 16'hDEAD;
    outside_input = 16'hBAD0;
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      #1 check("wait_stall", stall, 1'b1);
      tick();
      check("wait_req", mem_req, 1'b1);
      check("wait_addr", mem_addr, addr);
    end
    if (to) begin
      mem_ready = 1'b0;
      #1 check("abort_stall", stall, 1'b0);
      tick();
      model_to = 1'b1;
      check("to_err", timeout_err, 1'b1);
      check("to_req", mem_req, 1'b0);
    end else begin
      mem_ready     = 1'b1;
      outside_input = rdata;
      #1 check("ready_stall", stall, 1'b0);
      tick();
      check("done_req", mem_req, 1'b0);
      check("done_we", mem_we, 1'b0);
      check("done_to", timeout_err, model_to);
    end
    idle_inputs();
    pop_mdr("op_mdr");
  endtask

  initial begin
    reset         = 1'b0;
    addr_in       = 16'h0;
    data_bus      = 16'h0;
    outside_input = 16'h0;
    model_mdr     = 16'h0;
    model_wdata   = 16'h0;
    model_to      = 1'b0;
    idle_inputs();
    tick();
    tick();
    check("rst_mdr", mdr_out, 16'h0);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 16'h0);
    check("rst_wdata", mem_wdata, 16'h0);
    check("rst_stall", stall, 1'b0);
    check("rst_to", timeout_err, 1'b0);
    reset = 1'b1;
    tick();

    bus_load(16'hA5A5);

    // Off-phase: nothing captured.
    phase_counter = 3'd3;
    data_bus      = 16'hFFFF;
    tick();
    check("hold_mdr", mdr_out, model_mdr);

    mem_op(1'b1, 1'b0, 16'h0040, 2, 16'h1234, 1'b0);
    bus_load(16'h00FF);
    mem_op(1'b0, 1'b1, 16'h0080, 0, 16'h7777, 1'b0);
    mem_op(1'b1, 1'b1, 16'h0100, 1, 16'hBEEF, 1'b0);

    // op_mdr=1 with neither read nor write.
    phase_counter = 3'd4;
    op_mdr        = 1'b1;
    #1 check("noop_stall", stall, 1'b0);
    tick();
    idle_inputs();
    check("noop_req", mem_req, 1'b0);
    check("noop_mdr", mdr_out, model_mdr);

    // Ready while idle is ignored.
    mem_ready     = 1'b1;
    outside_input = 16'h9999;
    #1 check("idle_rdy_stall", stall, 1'b0);
    tick();
    mem_ready = 1'b0;
    check("idle_rdy_mdr", mdr_out, model_mdr);
    check("idle_rdy_req", mem_req, 1'b0);

    mem_op(1'b1, 1'b0, 16'h0200, 15, 16'h4242, 1'b1);
    bus_load(16'h5555);
    check("to_sticky", timeout_err, 1'b1);
    mem_op(1'b1, 1'b0, 16'h0300, 0, 16'h6666, 1'b0);

    // Reset in the middle of a read.
    phase_counter = 3'd4;
    op_mdr        = 1'b1;
    mem_read      = 1'b1;
    addr_in       = 16'h0400;
    tick();
    idle_inputs();
    tick();
    check("mid_req", mem_req, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst_mdr", mdr_out, 16'h0);
    check("mrst_req", mem_req, 1'b0);
    check("mrst_addr", mem_addr, 16'h0);
    check("mrst_to", timeout_err, 1'b0);
    check("mrst_stall", stall, 1'b0);
    mem_ready     = 1'b1;
    outside_input = 16'hCAFE;
    tick();
    mem_ready = 1'b0;
    check("late_rdy_mdr", mdr_out, 16'h0);
    check("late_rdy_req", mem_req, 1'b0);
    check("q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
